// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: priority stall/flush arbiter with redirect hold, stall watchdog and perf counters
// Ports: clk, rst_n (async active-low); req_i hazard requests (higher index wins);
// stall_o/flush_o per-stage masks of the winner; win_valid_o/win_idx_o winner info;
// redirect_busy_o redirect hold active; deadlock_o sticky watchdog flag, wdog_clr_i clears it;
// perf_sel_i/perf_clr_i/perf_cnt_o registered readout and clear of per-source winner-cycle counters.
module pipeline_hazard_ctrl #(
  parameter int NUM_STAGES = 6,
  parameter int NUM_REQ = 4,
  parameter logic [NUM_REQ*NUM_STAGES-1:0] STALL_MASKS = {6'b001111, 6'b000010, 6'b000010, 6'b000011},
  parameter logic [NUM_REQ*NUM_STAGES-1:0] FLUSH_MASKS = {6'b010000, 6'b001110, 6'b000110, 6'b000100},
  parameter logic [NUM_REQ-1:0] REDIRECT_MASK = 4'b0100,
  parameter int REDIRECT_CYCLES = 2,
  parameter logic [NUM_STAGES-1:0] RST_FLUSH = 6'b011111,
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W = 32,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  win_valid_o,
  output logic [IW-1:0]         win_idx_o,
  output logic                  redirect_busy_o,
  output logic                  deadlock_o,
  input  logic                  wdog_clr_i,
  input  logic [IW-1:0]         perf_sel_i,
  input  logic                  perf_clr_i,
  output logic [CNT_W-1:0]      perf_cnt_o
);
  localparam int CW = $clog2(REDIRECT_CYCLES + 1);
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nx;
  logic [NUM_REQ-1:0] hold_vec, hold_nx, eff;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] w;
  logic act, reload;
  logic [WW-1:0] wcnt;
  logic [CNT_W-1:0] pc [NUM_REQ];
  assign eff = req_i | hold_vec;
  always_comb begin
    w = '0;
    for (int i = 0; i < NUM_REQ; i++) if (eff[i]) w = IW'(i);
  end
  // outputs are forced to their reset values while rst_n is low, whatever req_i does
  assign act = rst_n && (eff != '0);
  assign win_valid_o = act;
  assign win_idx_o = act ? w : '0;
  assign stall_o = act ? STALL_MASKS[w*NUM_STAGES +: NUM_STAGES] : '0;
  assign flush_o = !rst_n ? RST_FLUSH : act ? FLUSH_MASKS[w*NUM_STAGES +: NUM_STAGES] : '0;
  assign redirect_busy_o = state == HOLD;
  // only a live request re-arms the hold; the held source winning by itself just counts down
  assign reload = act && REDIRECT_MASK[w] && req_i[w];
  always_comb begin
    state_nx = state;
    hold_nx = hold_vec;
    cnt_nx = cnt;
    if (reload) begin
      state_nx = HOLD;
      hold_nx = NUM_REQ'(1) << w;
      cnt_nx = CW'(REDIRECT_CYCLES);
    end else if (state == HOLD) begin
      state_nx = cnt == CW'(1) ? IDLE : HOLD;
      hold_nx = cnt == CW'(1) ? '0 : hold_vec;
      cnt_nx = cnt - CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hold_vec <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      hold_vec <= hold_nx;
      cnt <= cnt_nx;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= '0;
      deadlock_o <= 1'b0;
    end else if (wdog_clr_i) begin
      wcnt <= '0;
      deadlock_o <= 1'b0;
    end else if (stall_o == '0) begin
      wcnt <= '0;
    end else begin
      if (wcnt != WW'(WDOG_LIMIT)) wcnt <= wcnt + WW'(1);
      if (wcnt >= WW'(WDOG_LIMIT - 1)) deadlock_o <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) pc[i] <= '0;
      perf_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (perf_clr_i) pc[i] <= '0;
        else if (act && w == IW'(i) && pc[i] != '1) pc[i] <= pc[i] + CNT_W'(1);
      perf_cnt_o <= int'(perf_sel_i) < NUM_REQ ? pc[perf_sel_i] : '0;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven and sequence checks of pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_i = '0;
  logic wdog_clr_i = 1'b0;
  logic perf_clr_i = 1'b0;
  logic [1:0] perf_sel_i = '0;
  logic [5:0] stall_o, flush_o, s3_stall, s3_flush;
  logic win_valid_o, redirect_busy_o, deadlock_o, s3_valid, s3_busy, s3_dead;
  logic [1:0] win_idx_o, s3_idx;
  logic [31:0] perf_cnt_o;
  logic [2:0] s3_perf;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .stall_o(stall_o), .flush_o(flush_o),
    .win_valid_o(win_valid_o), .win_idx_o(win_idx_o), .redirect_busy_o(redirect_busy_o),
    .deadlock_o(deadlock_o), .wdog_clr_i(wdog_clr_i), .perf_sel_i(perf_sel_i),
    .perf_clr_i(perf_clr_i), .perf_cnt_o(perf_cnt_o)
  );
  pipeline_hazard_ctrl #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .stall_o(s3_stall), .flush_o(s3_flush),
    .win_valid_o(s3_valid), .win_idx_o(s3_idx), .redirect_busy_o(s3_busy),
    .deadlock_o(s3_dead), .wdog_clr_i(wdog_clr_i), .perf_sel_i(perf_sel_i),
    .perf_clr_i(perf_clr_i), .perf_cnt_o(s3_perf)
  );
  typedef struct {
    logic [3:0] req;
    logic [5:0] stall;
    logic [5:0] flush;
    logic valid;
    logic [1:0] idx;
    logic busy;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask
  task automatic add(input logic [3:0] r, input logic [5:0] s, input logic [5:0] f,
                     input logic v, input logic [1:0] ix, input logic b);
    vec_t e;
    e.req = r; e.stall = s; e.flush = f; e.valid = v; e.idx = ix; e.busy = b;
    tbl.push_back(e);
  endtask
  task automatic cyc(input logic [3:0] r);
    @(posedge clk);
    #1 req_i = r;
  endtask
  initial begin
    vec_t e;
    add(4'b0000, 6'b000000, 6'b000000, 0, 0, 0);
    add(4'b1011, 6'b001111, 6'b010000, 1, 3, 0);
    add(4'b0011, 6'b000010, 6'b000110, 1, 1, 0);
    add(4'b0001, 6'b000011, 6'b000100, 1, 0, 0);
    add(4'b0000, 6'b000000, 6'b000000, 0, 0, 0);
    add(4'b0100, 6'b000010, 6'b001110, 1, 2, 0);
    add(4'b0000, 6'b000010, 6'b001110, 1, 2, 1);
    add(4'b0000, 6'b000010, 6'b001110, 1, 2, 1);
    add(4'b0000, 6'b000000, 6'b000000, 0, 0, 0);
    add(4'b0100, 6'b000010, 6'b001110, 1, 2, 0);
    add(4'b1000, 6'b001111, 6'b010000, 1, 3, 1);
    add(4'b0000, 6'b000010, 6'b001110, 1, 2, 1);
    add(4'b0000, 6'b000000, 6'b000000, 0, 0, 0);
    add(4'b0100, 6'b000010, 6'b001110, 1, 2, 0);
    add(4'b0000, 6'b000010, 6'b001110, 1, 2, 1);
    add(4'b0100, 6'b000010, 6'b001110, 1, 2, 1);
    add(4'b0000, 6'b000010, 6'b001110, 1, 2, 1);
    add(4'b0000, 6'b000010, 6'b001110, 1, 2, 1);
    add(4'b0000, 6'b000000, 6'b000000, 0, 0, 0);
    add(4'b0100, 6'b000010, 6'b001110, 1, 2, 0);
    add(4'b0011, 6'b000010, 6'b001110, 1, 2, 1);
    add(4'b0001, 6'b000010, 6'b001110, 1, 2, 1);
    add(4'b0001, 6'b000011, 6'b000100, 1, 0, 0);
    add(4'b0000, 6'b000000, 6'b000000, 0, 0, 0);
    add(4'b1111, 6'b001111, 6'b010000, 1, 3, 0);
    add(4'b0000, 6'b000000, 6'b000000, 0, 0, 0);
    @(negedge clk);
    chk("rst stall", 32'(stall_o), 0);
    chk("rst flush", 32'(flush_o), 32'b011111);
    chk("rst valid", 32'(win_valid_o), 0);
    chk("rst idx", 32'(win_idx_o), 0);
    chk("rst busy", 32'(redirect_busy_o), 0);
    chk("rst deadlock", 32'(deadlock_o), 0);
    chk("rst perf", perf_cnt_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].req);
      sb.push_back(tbl[k]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("row%0d stall", k), 32'(stall_o), 32'(e.stall));
      chk($sformatf("row%0d flush", k), 32'(flush_o), 32'(e.flush));
      chk($sformatf("row%0d valid", k), 32'(win_valid_o), 32'(e.valid));
      chk($sformatf("row%0d idx", k), 32'(win_idx_o), 32'(e.idx));
      chk($sformatf("row%0d busy", k), 32'(redirect_busy_o), 32'(e.busy));
    end
    cyc(4'b0100);
    cyc(4'b0000);
    #1 chk("midhold busy", 32'(redirect_busy_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(redirect_busy_o), 0);
    chk("midrst stall", 32'(stall_o), 0);
    chk("midrst flush", 32'(flush_o), 32'b011111);
    chk("midrst valid", 32'(win_valid_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst stall", 32'(stall_o), 0);
    chk("postrst flush", 32'(flush_o), 0);
    chk("postrst busy", 32'(redirect_busy_o), 0);
    for (int i = 0; i < 1023; i++) cyc(4'b0001);
    cyc(4'b0000);
    @(negedge clk);
    chk("wdog 1023", 32'(deadlock_o), 0);
    for (int i = 0; i < 1024; i++) cyc(4'b0001);
    @(negedge clk);
    chk("wdog in 1024th", 32'(deadlock_o), 0);
    cyc(4'b0000);
    @(negedge clk);
    chk("wdog set", 32'(deadlock_o), 1);
    cyc(4'b0000);
    @(negedge clk);
    chk("wdog sticky", 32'(deadlock_o), 1);
    @(posedge clk);
    #1 wdog_clr_i = 1'b1;
    @(posedge clk);
    #1 wdog_clr_i = 1'b0;
    @(negedge clk);
    chk("wdog clr", 32'(deadlock_o), 0);
    @(posedge clk);
    #1 perf_clr_i = 1'b1;
    perf_sel_i = 2'd1;
    @(posedge clk);
    #1 perf_clr_i = 1'b0;
    for (int i = 0; i < 5; i++) cyc(4'b0010);
    cyc(4'b0000);
    @(posedge clk);
    #1;
    chk("perf5", perf_cnt_o, 5);
    chk("perf5 w3", 32'(s3_perf), 5);
    perf_clr_i = 1'b1;
    @(posedge clk);
    #1 perf_clr_i = 1'b0;
    @(posedge clk);
    #1 chk("perf clr", perf_cnt_o, 0);
    for (int i = 0; i < 9; i++) cyc(4'b0010);
    cyc(4'b0000);
    @(posedge clk);
    #1;
    chk("perf9", perf_cnt_o, 9);
    chk("perf sat w3", 32'(s3_perf), 7);
    perf_sel_i = 2'd0;
    @(posedge clk);
    #1 chk("perf sel0", perf_cnt_o, 0);
    perf_sel_i = 2'd3;
    @(posedge clk);
    #1 chk("perf sel3", perf_cnt_o, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised pipeline stall/flush arbiter for the NPC core. It is the generalised successor of the fixed 6-stage priority controller. Any number of hazard sources map to per-source stall/flush masks over any number of stages. Adds a redirect-hold FSM that keeps trap-class flushes asserted for a configurable number of cycles, a stall watchdog, and per-source saturating stall-cycle counters for performance analysis.

Parameters:
NUM_STAGES, 6, stage count; bit0=PC, bit1=Pre_IF, bit2=IF_ID, bit3=ID_EX, bit4=EX_MEM, bit5=MEM_WB
NUM_REQ, 4, number of hazard request sources; higher index = higher priority
STALL_MASKS, {6'b001111,6'b000010,6'b000010,6'b000011}, flattened; source i at [i*NUM_STAGES +: NUM_STAGES]
FLUSH_MASKS, {6'b010000,6'b001110,6'b000110,6'b000100}, flattened, same layout
REDIRECT_MASK, 4'b0100, sources whose win starts a redirect hold
REDIRECT_CYCLES, 2, extra cycles a redirect winner stays effective after it is seen (>=1)
RST_FLUSH, 6'b011111, flush_o value while in reset
WDOG_LIMIT, 1024, consecutive stall cycles before deadlock_o sets (>=2)
CNT_W, 32, perf counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  hazard requests; default map: 0 load-use, 1 jump, 2 trap, 3 mem-ram
stall_o  out  NUM_STAGES  per-stage stall
flush_o  out  NUM_STAGES  per-stage flush
win_valid_o  out  1  some source is currently effective
win_idx_o  out  clog2(NUM_REQ)  index of the winning source
redirect_busy_o  out  1  redirect hold active
deadlock_o  out  1  sticky watchdog flag
wdog_clr_i  in  1  clears deadlock_o and the watchdog count
perf_sel_i  in  clog2(NUM_REQ)  counter select
perf_clr_i  in  1  synchronous clear of all perf counters
perf_cnt_o  out  CNT_W  registered value of the selected counter

Behaviour:
- Reset (rst_n low, async): stall_o=0, flush_o=RST_FLUSH, win_valid_o=0, win_idx_o=0, redirect_busy_o=0, deadlock_o=0, perf_cnt_o=0. FSM goes to IDLE, all counters go to 0. Behaviour is identical if reset asserts mid-hold.
- Effective vector: eff = req_i | hold_vec. hold_vec is one-hot while in HOLD and 0 otherwise.
- Winner: the highest set index of eff. It is combinational, with same-cycle response to req_i.
  - When a winner exists: stall_o = STALL_MASKS[w], flush_o = FLUSH_MASKS[w], win_valid_o=1.
  - When eff=0: stall_o = flush_o = 0, win_valid_o=0, win_idx_o=0.
- FSM states:
  - IDLE: if the winner w has REDIRECT_MASK[w]=1, then on the next edge load hold_vec=onehot(w), cnt=REDIRECT_CYCLES, and go to HOLD.
  - HOLD: redirect_busy_o=1. Each cycle cnt decrements. When cnt reaches 1 and no reload occurs, the next edge goes to IDLE with hold_vec=0. The held source is therefore effective for REDIRECT_CYCLES cycles after its req_i drops.
- Reload in HOLD: if the current winner is a redirect source (the same source or a new one with req_i set), hold_vec and cnt reload on that edge. Because the winner is taken from eff, the hold source itself keeps winning.
- Higher-priority source during HOLD: it wins the outputs immediately. The hold keeps counting down underneath. If the higher-priority source is not a redirect source, there is no reload.
- Watchdog:
  - wcnt increments on every cycle with stall_o != 0 and resets to 0 on any cycle with stall_o == 0.
  - deadlock_o sets on the edge that ends the WDOG_LIMIT-th consecutive stall cycle. It is sticky, and wcnt saturates.
  - wdog_clr_i clears deadlock_o and wcnt, and takes priority over setting on the same edge.
- Perf counters:
  - pc[w] increments, saturating at 2^CNT_W-1, on each cycle where w is the winner. Held cycles count for the held source.
  - perf_clr_i zeroes all counters and beats any increment on the same edge.
  - perf_cnt_o <= pc[perf_sel_i] on every edge (1-cycle latency, pre-increment value). An out-of-range perf_sel_i gives 0.
- Parameter legality: the masks are used verbatim, with no internal consistency checks.

Test Plan:
1. Reset release with req_i=0 -> during reset flush_o=6'b011111 and stall_o=0; after release both outputs are 0, and win_valid_o=0.
2. Priority: req_i=4'b1011 -> stall_o=6'b001111, flush_o=6'b010000, win_idx_o=3. Then req_i=4'b0011 -> stall_o=6'b000010, flush_o=6'b000110, win_idx_o=1, in the same cycle.
3. Redirect hold: req_i[2] is high for 1 cycle (T), then 0. Required response:
   - Cycles T, T+1, T+2 show stall_o=6'b000010 and flush_o=6'b001110.
   - redirect_busy_o is high in T+1 and T+2.
   - At T+3 all outputs are 0.
   - A req_i[3] pulse at T+1 overrides to 001111/010000 for that cycle only, and T+2 shows trap masks again.
4. Reload: req_i[2] pulses at T and again at T+2 -> trap masks are held through T+4, and redirect_busy_o drops at T+5.
5. Watchdog (WDOG_LIMIT=1024): req_i[0] held for 1023 cycles -> deadlock_o stays 0. One cycle of req_i=0 resets wcnt. Holding req_i[0] for 1024 cycles -> deadlock_o=1 on the next cycle and it stays 1 after req drops. wdog_clr_i -> deadlock_o=0.
6. Perf: req_i[1] for 5 cycles, then perf_sel_i=1 -> perf_cnt_o=5 one cycle later. perf_clr_i -> 0. With CNT_W=3, 9 cycles of req_i[1] -> counter saturates at 7.
